// File: rtl/uart_resend_sched_pkg.sv
// Shared definitions for the resend back-channel scheduler.
//   state_e  : scheduler FSM states (2-bit encoding)
//   RETRY_W  : per-channel retry counter width (matches receiver resend_count)
//   CH_IDX_W : width of the back-channel channel index
//   sat_inc  : saturating increment for retry counters
package uart_resend_sched_pkg;

  localparam int RETRY_W  = 5;
  localparam int CH_IDX_W = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_WAIT  = 2'd2,
    S_GAP   = 2'd3
  } state_e;

  function automatic logic [RETRY_W-1:0] sat_inc(input logic [RETRY_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/uart_resend_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req  : request vector (one bit per channel)
//   ptr  : highest-priority index this round
//   gnt  : one-hot grant for the first request at or after ptr (wrapping)
//   idx  : binary index of the granted channel, zero-extended
//   any  : at least one request present
module uart_resend_sched_rr_arbiter
  import uart_resend_sched_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]          req,
  input  logic [CH_IDX_W-1:0]   ptr,
  output logic [N-1:0]          gnt,
  output logic [CH_IDX_W-1:0]   idx,
  output logic                  any
);

  localparam int IW = $clog2(N);

  int            sum;
  logic [IW-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    sum  = 0;
    cand = '0;
    // Walk N slots starting at ptr; the first hit wins.
    for (int off = 0; off < N; off++) begin
      sum = int'(ptr) + off;
      if (sum >= N) sum = sum - N;
      cand = IW'(sum);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = CH_IDX_W'(sum);
      end
    end
  end

endmodule

// File: rtl/uart_resend_sched.sv
// Round-robin scheduler sharing one resend back-channel among N_CH receivers.
//   clk, reset   : clock, synchronous active-high reset
//   ch_req       : request_resend level per receiver
//   ch_valid     : frame-accepted pulse per receiver; clears its retry budget
//   ch_ack       : one-hot, one-cycle ack to the granted receiver
//   bc_start     : one-cycle start pulse to the back-channel
//   bc_ch        : channel index for the back-channel, held through the transaction
//   bc_done      : back-channel completion pulse
//   give_up      : sticky per channel, retry budget exhausted
//   timeout_err  : one-cycle pulse when the back-channel times out
//   busy         : scheduler not idle
module uart_resend_sched
  import uart_resend_sched_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int MAX_RETRY = 5,
  parameter int TIMEOUT   = 16,
  parameter int GAP       = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_CH-1:0]     ch_req,
  input  logic [N_CH-1:0]     ch_valid,
  output logic [N_CH-1:0]     ch_ack,
  output logic                bc_start,
  output logic [CH_IDX_W-1:0] bc_ch,
  input  logic                bc_done,
  output logic [N_CH-1:0]     give_up,
  output logic                timeout_err,
  output logic                busy
);

  localparam logic [RETRY_W-1:0]  MAX_R    = RETRY_W'(MAX_RETRY);
  localparam logic [7:0]          TO_LAST  = 8'(TIMEOUT - 1);
  // GAP=0 still spends one cycle in S_GAP.
  localparam logic [7:0]          GAP_LAST = 8'((GAP == 0) ? 0 : GAP - 1);
  localparam logic [CH_IDX_W-1:0] LAST_CH  = CH_IDX_W'(N_CH - 1);

  state_e                           state_q, state_d;
  logic [7:0]                       timer_q, timer_d;
  logic [CH_IDX_W-1:0]              rr_ptr_q, rr_ptr_d;
  logic [CH_IDX_W-1:0]              bc_ch_q, bc_ch_d;
  logic [N_CH-1:0]                  gnt_q, gnt_d;
  logic [N_CH-1:0][RETRY_W-1:0]     retry_q, retry_d;
  logic [N_CH-1:0]                  give_up_q, give_up_d;

  logic [N_CH-1:0]     arb_gnt;
  logic [CH_IDX_W-1:0] arb_idx;
  logic                arb_any;
  logic [N_CH-1:0]     at_max_vec;
  logic [N_CH-1:0]     ack_c;
  logic                start_c, to_c;

  uart_resend_sched_rr_arbiter #(.N(N_CH)) u_arb (
    .req (ch_req & ~give_up_q),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_comb begin
    for (int i = 0; i < N_CH; i++) at_max_vec[i] = (retry_q[i] == MAX_R);
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    rr_ptr_d  = rr_ptr_q;
    bc_ch_d   = bc_ch_q;
    gnt_d     = gnt_q;
    retry_d   = retry_q;
    give_up_d = give_up_q;
    ack_c     = '0;
    start_c   = 1'b0;
    to_c      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (arb_any) begin
          bc_ch_d = arb_idx;
          gnt_d   = arb_gnt;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (|(gnt_q & at_max_vec)) begin
          give_up_d = give_up_q | gnt_q;
          state_d   = S_IDLE;
        end else begin
          ack_c   = gnt_q;
          start_c = 1'b1;
          for (int i = 0; i < N_CH; i++)
            if (gnt_q[i]) retry_d[i] = sat_inc(retry_q[i]);
          timer_d = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // done takes priority over a same-cycle timeout
        if (bc_done) begin
          timer_d = '0;
          state_d = S_GAP;
        end else if (timer_q == TO_LAST) begin
          to_c    = 1'b1;
          timer_d = '0;
          state_d = S_GAP;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_GAP: begin
        if (timer_q == GAP_LAST) begin
          rr_ptr_d = (bc_ch_q == LAST_CH) ? '0 : bc_ch_q + 1'b1;
          state_d  = S_IDLE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Frame accepted: clear budget; overrides a same-edge increment or give_up.
    for (int i = 0; i < N_CH; i++) begin
      if (ch_valid[i]) begin
        retry_d[i]   = '0;
        give_up_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      rr_ptr_q  <= '0;
      bc_ch_q   <= '0;
      gnt_q     <= '0;
      retry_q   <= '0;
      give_up_q <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      rr_ptr_q  <= rr_ptr_d;
      bc_ch_q   <= bc_ch_d;
      gnt_q     <= gnt_d;
      retry_q   <= retry_d;
      give_up_q <= give_up_d;
    end
  end

  // Pulses are masked during reset so an aborted GRANT never leaks an ack.
  assign ch_ack      = reset ? '0 : ack_c;
  assign bc_start    = ~reset & start_c;
  assign timeout_err = ~reset & to_c;
  assign bc_ch       = bc_ch_q;
  assign give_up     = give_up_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_resend_sched.sv
module tb_uart_resend_sched;

  localparam int N    = 4;
  localparam int MAXR = 5;
  localparam int TO   = 16;
  localparam int GP   = 2;
  localparam int INF  = 32'h7fffffff;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] ch_req = '0;
  logic [N-1:0] ch_valid = '0;
  logic         bc_done = 1'b0;
  logic [N-1:0] ch_ack, give_up;
  logic         bc_start, timeout_err, busy;
  logic [2:0]   bc_ch;

  int total = 0;
  int bad   = 0;

  uart_resend_sched #(.N_CH(N), .MAX_RETRY(MAXR), .TIMEOUT(TO), .GAP(GP)) dut (
    .clk         (clk),
    .reset       (reset),
    .ch_req      (ch_req),
    .ch_valid    (ch_valid),
    .ch_ack      (ch_ack),
    .bc_start    (bc_start),
    .bc_ch       (bc_ch),
    .bc_done     (bc_done),
    .give_up     (give_up),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (event-time based) ----------------
  // A transaction is described by absolute cycle numbers: when the grant
  // happens, and the first cycle the scheduler is free again.
  int           cyc = 0;
  bit           seen_rst = 1'b0;
  int           idle_at = 0, grant_at = -1;
  bit           m_wait = 1'b0;
  int           m_g = 0, m_ptr = 0, m_bcch = 0;
  int           m_retry [N];
  logic [N-1:0] m_gu = '0;
  logic [N-1:0] elig, e_ack, e_gu;
  logic         e_start, e_to, e_busy;
  int           e_bcch, c_m;
  bit           fnd;

  always @(posedge clk) begin
    #4;
    e_busy = (cyc < idle_at);
    e_gu   = m_gu;
    e_bcch = m_bcch;
    e_ack  = '0;
    e_start = 1'b0;
    e_to   = 1'b0;
    if (reset) begin
      if (seen_rst) begin
        chk("m_rst_ack", 32'(ch_ack), 32'(e_ack));
        chk("m_rst_start", 32'(bc_start), 32'(e_start));
        chk("m_rst_to", 32'(timeout_err), 32'(e_to));
        chk("m_rst_busy", 32'(busy), 32'(e_busy));
      end
      seen_rst = 1'b1;
      idle_at = cyc + 1; grant_at = -1; m_wait = 1'b0;
      m_g = 0; m_ptr = 0; m_bcch = 0; m_gu = '0;
      for (int i = 0; i < N; i++) m_retry[i] = 0;
    end else if (seen_rst) begin
      if (!e_busy) begin
        elig = ch_req & ~m_gu;
        fnd = 1'b0;
        for (int k = 0; k < N; k++) begin
          c_m = (m_ptr + k) % N;
          if (!fnd && elig[c_m]) begin fnd = 1'b1; m_g = c_m; end
        end
        if (fnd) begin
          grant_at = cyc + 1; idle_at = INF; m_bcch = m_g;
        end
      end else if (cyc == grant_at) begin
        if (m_retry[m_g] == MAXR) begin
          m_gu[m_g] = 1'b1; idle_at = cyc + 1;
        end else begin
          e_ack[m_g] = 1'b1; e_start = 1'b1;
          if (m_retry[m_g] < 31) m_retry[m_g]++;
          m_wait = 1'b1;
        end
      end else if (m_wait) begin
        if (bc_done || (cyc - grant_at == TO)) begin
          e_to = !bc_done;
          m_wait = 1'b0;
          idle_at = cyc + 1 + ((GP > 0) ? GP : 1);
          m_ptr = (m_g + 1) % N;
        end
      end
      for (int i = 0; i < N; i++)
        if (ch_valid[i]) begin m_retry[i] = 0; m_gu[i] = 1'b0; end
      chk("m_ack", 32'(ch_ack), 32'(e_ack));
      chk("m_start", 32'(bc_start), 32'(e_start));
      chk("m_to", 32'(timeout_err), 32'(e_to));
      chk("m_busy", 32'(busy), 32'(e_busy));
      chk("m_gu", 32'(give_up), 32'(e_gu));
      chk("m_bcch", 32'(bc_ch), 32'(e_bcch));
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  int cd = 0;
  int resp_delay = 1;

  // Advance one clock; back-channel responder asserts bc_done resp_delay
  // cycles after each observed bc_start (0 = never answer).
  task automatic step();
    logic s0;
    #2;
    s0 = bc_start;
    @(posedge clk);
    #1;
    if (s0) cd = resp_delay;
    else if (cd > 0) cd--;
    bc_done = (cd == 1);
  endtask

  task automatic look();
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    look();
    while (busy && k < 80) begin step(); look(); k++; end
    chk(nm, 32'(busy), 32'h0);
  endtask

  logic [N-1:0] seq [4];
  int na, extra, k, got;

  initial begin
    // 1: reset and quiet idle
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      look();
      chk("t1_idle", 32'({ch_ack, bc_start, timeout_err, busy, give_up, bc_ch}), 32'h0);
      step();
    end

    // 2: single request, done 3 cycles after start
    ch_req = 4'b0001; resp_delay = 3;
    look(); chk("t2_pre_busy", 32'(busy), 32'h0);
    step();
    ch_req = 4'b0000;
    look();
    chk("t2_ack", 32'(ch_ack), 32'h1);
    chk("t2_start", 32'(bc_start), 32'h1);
    chk("t2_bcch", 32'(bc_ch), 32'h0);
    for (int i = 0; i < 5; i++) step();
    look(); chk("t2_busy_gap", 32'(busy), 32'h1);
    step();
    look(); chk("t2_idle", 32'(busy), 32'h0);

    // 3: two requesters alternate, pointer wraps
    ch_req = 4'b1010; resp_delay = 1; na = 0;
    for (int c = 0; c < 80 && na < 4; c++) begin
      look();
      if (ch_ack != 0) begin seq[na] = ch_ack; na++; end
      step();
    end
    chk("t3_n", 32'(na), 32'h4);
    chk("t3_g0", 32'(seq[0]), 32'h2);
    chk("t3_g1", 32'(seq[1]), 32'h8);
    chk("t3_g2", 32'(seq[2]), 32'h2);
    chk("t3_g3", 32'(seq[3]), 32'h8);
    ch_req = 4'b0000;
    wait_idle("t3_idle");
    step();
    ch_valid = 4'hf; step(); ch_valid = '0;

    // 4: budget exhaustion and recovery
    ch_req = 4'b0100; resp_delay = 1; na = 0;
    for (int c = 0; c < 120; c++) begin
      look();
      if (ch_ack == 4'b0100) na++;
      if (give_up[2]) break;
      step();
    end
    chk("t4_acks", 32'(na), 32'h5);
    chk("t4_gu", 32'(give_up), 32'h4);
    extra = 0;
    for (int i = 0; i < 15; i++) begin
      step(); look();
      if (ch_ack != 0) extra++;
    end
    chk("t4_no_6th", 32'(extra), 32'h0);
    ch_valid = 4'b0100; step(); ch_valid = '0;
    look(); chk("t4_clr", 32'(give_up), 32'h0);
    got = 0;
    for (int c = 0; c < 20; c++) begin
      look();
      if (ch_ack == 4'b0100) begin got = 1; break; end
      step();
    end
    chk("t4_reack", 32'(got), 32'h1);
    ch_req = 4'b0000;
    wait_idle("t4_idle");
    step();

    // 5: timeout, then done landing exactly on the timeout cycle
    ch_req = 4'b0001; resp_delay = 0;
    step(); ch_req = 4'b0000;
    look(); chk("t5_start", 32'(bc_start), 32'h1);
    k = 0;
    while (!timeout_err && k < 40) begin step(); look(); k++; end
    chk("t5_to_dist", 32'(k), 32'h10);
    wait_idle("t5_idle");
    step();
    ch_req = 4'b0001; resp_delay = TO;
    step(); ch_req = 4'b0000;
    look(); chk("t5b_start", 32'(bc_start), 32'h1);
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      step(); look();
      if (timeout_err) extra++;
    end
    chk("t5b_no_to", 32'(extra), 32'h0);
    wait_idle("t5b_idle");
    step();

    // 6: reset during GRANT, then during WAIT
    ch_req = 4'b0010; resp_delay = 0;
    step(); ch_req = 4'b0000;
    look(); chk("t6_bcch", 32'(bc_ch), 32'h1);
    reset = 1'b1;
    look(); chk("t6_rst_pulses", 32'({ch_ack, bc_start}), 32'h0);
    step(); reset = 1'b0;
    look();
    chk("t6_busy", 32'(busy), 32'h0);
    chk("t6_bcch0", 32'(bc_ch), 32'h0);
    ch_req = 4'b0010;
    step(); ch_req = 4'b0000;
    step(); step();
    look(); chk("t6_in_wait", 32'(busy), 32'h1);
    reset = 1'b1;
    step(); reset = 1'b0;
    look();
    chk("t6w_state", 32'({ch_ack, bc_start, timeout_err, busy, give_up, bc_ch}), 32'h0);

    // random traffic, checked cycle by cycle by the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) ch_req = 4'($urandom);
      ch_valid = ($urandom_range(0, 15) == 0) ? 4'(1 << $urandom_range(0, N - 1)) : 4'h0;
      resp_delay = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 20));
      reset = ($urandom_range(0, 499) == 0);
      step();
    end
    reset = 1'b0; ch_req = '0; ch_valid = '0;
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
